// File: rtl/jtframe_clk_seq.sv
// Reset and clock-enable sequencer for the 96 MHz frame clock: qualifies PLL lock,
// releases SDRAM then game reset in order, and derives phase-aligned 48/24/12/6 MHz enables.
module jtframe_clk_seq #(
  parameter int unsigned LOCK_CYCLES = 256,
  parameter int unsigned GAME_CYCLES = 64,
  parameter int unsigned CNT_W       = 12
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pll_locked,
  input  logic sdram_init_done,
  input  logic soft_rst,
  output logic sdram_rst,
  output logic game_rst,
  output logic ready,
  output logic cen48,
  output logic cen24,
  output logic cen12,
  output logic cen6
);

  localparam int unsigned CEN_W = 4;
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAME_LAST = CNT_W'(GAME_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_WAIT_LOCK,
    ST_LOCK_QUAL,
    ST_SDRAM_INIT,
    ST_GAME_HOLD,
    ST_RUN
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CEN_W-1:0]   cnt4_q, cnt4_d;
  logic [1:0]         sync_q, sync_d;
  logic               sdram_rst_q, sdram_rst_d;
  logic               game_rst_q, game_rst_d;
  logic               ready_q, ready_d;
  logic [3:0]         cen_q, cen_d;   // {cen6, cen12, cen24, cen48}
  logic               lock_s;

  assign lock_s = sync_q[1];

  // State register and all other flops
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_WAIT_LOCK;
      cnt_q       <= '0;
      cnt4_q      <= '0;
      sync_q      <= '0;
      sdram_rst_q <= 1'b1;
      game_rst_q  <= 1'b1;
      ready_q     <= 1'b0;
      cen_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cnt4_q      <= cnt4_d;
      sync_q      <= sync_d;
      sdram_rst_q <= sdram_rst_d;
      game_rst_q  <= game_rst_d;
      ready_q     <= ready_d;
      cen_q       <= cen_d;
    end
  end

  // Next-state and shared delay counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sync_d  = {sync_q[0], pll_locked};
    case (state_q)
      ST_WAIT_LOCK: begin
        if (lock_s) begin
          state_d = ST_LOCK_QUAL;
          cnt_d   = '0;
        end
      end
      ST_LOCK_QUAL: begin
        if (cnt_q == LOCK_LAST) state_d = ST_SDRAM_INIT;
        else                    cnt_d   = cnt_q + CNT_W'(1);
      end
      ST_SDRAM_INIT: begin
        if (sdram_init_done) begin
          state_d = ST_GAME_HOLD;
          cnt_d   = '0;
        end
      end
      ST_GAME_HOLD: begin
        if (soft_rst)                cnt_d   = '0;
        else if (cnt_q == GAME_LAST) state_d = ST_RUN;
        else                         cnt_d   = cnt_q + CNT_W'(1);
      end
      ST_RUN: begin
        if (soft_rst) begin
          state_d = ST_GAME_HOLD;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_WAIT_LOCK;
        cnt_d   = '0;
      end
    endcase
    // Lock loss overrides every other transition, soft reset included
    if (!lock_s && (state_q != ST_WAIT_LOCK)) begin
      state_d = ST_WAIT_LOCK;
      cnt_d   = '0;
    end
  end

  // Outputs are registered from the next state so they line up with the state register
  always_comb begin
    sdram_rst_d = (state_d == ST_WAIT_LOCK) || (state_d == ST_LOCK_QUAL);
    game_rst_d  = (state_d != ST_RUN);
    ready_d     = (state_d == ST_RUN);
    cnt4_d      = '0;
    if ((state_q != ST_WAIT_LOCK) && (state_d != ST_WAIT_LOCK)) begin
      cnt4_d = cnt4_q + CEN_W'(1);
    end
    cen_d = {cnt4_d == 4'd15, cnt4_d[2:0] == 3'd7, cnt4_d[1:0] == 2'd3, cnt4_d[0]};
  end

  assign sdram_rst = sdram_rst_q;
  assign game_rst  = game_rst_q;
  assign ready     = ready_q;
  assign cen48     = cen_q[0];
  assign cen24     = cen_q[1];
  assign cen12     = cen_q[2];
  assign cen6      = cen_q[3];

endmodule

// File: tb/tb_jtframe_clk_seq.sv
// Scoreboard bench for jtframe_clk_seq: an age/hold-time reference model predicts every
// output cycle, a monitor compares the DUT one step after each rising edge.
module tb_jtframe_clk_seq;

  localparam int unsigned L  = 8;
  localparam int unsigned G  = 4;
  localparam int unsigned CW = 4;

  typedef logic [6:0] exp_t;  // {sdram_rst, game_rst, ready, cen48, cen24, cen12, cen6}

  logic clk = 1'b0;
  logic rst_n, pll_locked, sdram_init_done, soft_rst;
  logic sdram_rst, game_rst, ready, cen48, cen24, cen12, cen6;

  always #5 clk = ~clk;

  jtframe_clk_seq #(
    .LOCK_CYCLES (L),
    .GAME_CYCLES (G),
    .CNT_W       (CW)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .pll_locked      (pll_locked),
    .sdram_init_done (sdram_init_done),
    .soft_rst        (soft_rst),
    .sdram_rst       (sdram_rst),
    .game_rst        (game_rst),
    .ready           (ready),
    .cen48           (cen48),
    .cen24           (cen24),
    .cen12           (cen12),
    .cen6            (cen6)
  );

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc      = 0;

  // Reference model: lock age in synchronized-lock cycles and time since the last game-hold start
  logic        m_h0, m_h1;
  int unsigned m_age, m_since;
  logic        m_started;

  int cen_left = 0;
  int c48 = 0, c24 = 0, c12 = 0, c6 = 0, c_bad = 0;

  function automatic logic m_ready();
    return m_started && (m_since >= G);
  endfunction

  function automatic exp_t model_out();
    int unsigned ph;
    logic s, r;
    ph = (m_age == 0) ? 0 : (m_age - 1) % 16;
    s  = (m_age < L + 1);
    r  = m_ready();
    return {s, !r, r, (ph % 2) == 1, (ph % 4) == 3, (ph % 8) == 7, ph == 15};
  endfunction

  task automatic model_step(input logic rn, input logic pl, input logic dn, input logic sf);
    logic ls, past;
    if (!rn) begin
      m_h0 = 1'b0; m_h1 = 1'b0; m_age = 0; m_started = 1'b0; m_since = 0;
    end else begin
      ls   = m_h1;
      m_h1 = m_h0;
      m_h0 = pl;
      if (!ls) begin
        m_age = 0; m_started = 1'b0; m_since = 0;
      end else begin
        past  = (m_age >= L + 1);
        m_age = m_age + 1;
        if (past) begin
          if (!m_started) begin
            if (dn) begin m_started = 1'b1; m_since = 0; end
          end else if (sf) begin
            m_since = 0;
          end else if (m_since < G) begin
            m_since = m_since + 1;
          end
        end
      end
    end
  endtask

  task automatic drive(input logic rn, input logic pl, input logic dn, input logic sf);
    @(negedge clk);
    rst_n = rn; pll_locked = pl; sdram_init_done = dn; soft_rst = sf;
    model_step(rn, pl, dn, sf);
    exp_q.push_back(model_out());
  endtask

  task automatic check_int(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_errors++;
      $display("FAIL %s: got %0d want %0d", name, act, req);
    end
  endtask

  task automatic run_until_ready(input string name, input int budget);
    int n = 0;
    while (!m_ready() && n < budget) begin
      drive(1'b1, 1'b1, 1'b1, 1'b0);
      n++;
    end
    check_int({name, "_reached_ready"}, int'(m_ready()), 1);
  endtask

  // Monitor: pops one expectation per clock and compares the registered outputs
  initial begin
    exp_t e, a;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {sdram_rst, game_rst, ready, cen48, cen24, cen12, cen6};
        n_checks++;
        if (a !== e) begin
          n_errors++;
          $display("FAIL outputs cyc %0d: got %b want %b (sdram,game,ready,c48,c24,c12,c6)",
                   cyc, a, e);
        end
        if (cen_left > 0) begin
          cen_left--;
          c48 += int'(cen48); c24 += int'(cen24); c12 += int'(cen12); c6 += int'(cen6);
          if (cen6 && !(cen12 && cen24 && cen48)) c_bad++;
        end
      end
    end
  end

  initial begin
    int n;
    logic pl, rn;
    rst_n = 1'b0; pll_locked = 1'b0; sdram_init_done = 1'b0; soft_rst = 1'b0;

    // Power-up: reset values, lock at cycle 10, init done 20 cycles after sdram_rst falls
    repeat (3) drive(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (10) drive(1'b1, 1'b0, 1'b0, 1'b0);
    n = 0;
    while (m_age < L + 1 && n < 100) begin drive(1'b1, 1'b1, 1'b0, 1'b0); n++; end
    check_int("pwr_sdram_release_cycles", n, 3 + L);
    repeat (19) drive(1'b1, 1'b1, 1'b0, 1'b0);
    run_until_ready("pwr", 50);
    repeat (10) drive(1'b1, 1'b1, 1'b0, 1'b0);

    // Soft reset: single pulse, then two pulses two cycles apart
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    repeat (8) drive(1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    repeat (10) drive(1'b1, 1'b1, 1'b0, 1'b0);

    // Clock-enable window in RUN
    cen_left = 64;
    repeat (64) drive(1'b1, 1'b1, 1'b0, 1'b0);

    // Lock loss in RUN, then relock; glitch during qualification forces a full requal
    repeat (4) drive(1'b1, 1'b0, 1'b0, 1'b0);
    n = 0;
    while (m_age < 4 && n < 50) begin drive(1'b1, 1'b1, 1'b0, 1'b0); n++; end
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (6) drive(1'b1, 1'b1, 1'b0, 1'b0);
    run_until_ready("glitch", 100);

    // rst_n pulse during GAME_HOLD restarts from power-up state
    drive(1'b1, 1'b1, 1'b1, 1'b1);
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 1'b0);
    run_until_ready("rst_hold", 100);

    // Randomized traffic
    pl = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (pl) pl = ($urandom_range(0, 149) != 0);
      else    pl = ($urandom_range(0, 2) == 0);
      rn = ($urandom_range(0, 799) != 0);
      drive(rn, pl, $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
    end
    repeat (3) drive(1'b1, 1'b1, 1'b0, 1'b0);

    n = 0;
    while (exp_q.size() > 0 && n < 10) begin @(posedge clk); #2; n++; end
    check_int("scoreboard_drained", exp_q.size(), 0);
    check_int("cen48_count", c48, 32);
    check_int("cen24_count", c24, 16);
    check_int("cen12_count", c12, 8);
    check_int("cen6_count", c6, 4);
    check_int("cen6_coincidence_violations", c_bad, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
